fp16_stream_accumulator: RTL and testbench

- Sequential stage directly downstream of the combinational fp16_adder, and its only driver.
- Accepts a burst of IEEE-754 half-precision values over a valid/ready stream and keeps a running sum in a register. On each beat the sum is fed back into fp16_adder as operand a, and the new value is operand b.
- On the final beat it presents the registered total, element count and status flags on a valid/ready output port.
- Used for reductions such as dot-product tails and vector sums in the FP datapath.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_adder.sv | 75 +++++++
 rtl/fp16_stream_accumulator.sv | 127 ++++++++++++
 tb/tb_fp16_stream_accumulator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 constants, classification helpers and the stream accumulator state encoding.
package fp16_pkg;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_DONE  = 2'd2
  } acc_state_e;

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] x);
    return x[14:0] == FP16_POS_INF[14:0];
  endfunction

endpackage

// File: rtl/fp16_adder.sv
// Combinational IEEE-754 half-precision adder, round-to-nearest-even, denormal aware.
module fp16_adder
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic        swap_s, eff_sub_s, round_up_s;
  logic [15:0] x_s, y_s;
  logic [5:0]  x_exp_s, y_exp_s, diff_s, shamt_s, exp_s, exp_f_s;
  logic [13:0] x_man_s, y_man_s, y_al_s, norm_s;
  logic [27:0] y_shift_s;
  logic [14:0] raw_s;
  logic [11:0] rnd_s;
  logic [10:0] man_s;

  // Align, add, normalise and round; the larger magnitude is always x so the result sign is x's.
  always_comb begin
    swap_s    = b[14:0] > a[14:0];
    x_s       = swap_s ? b : a;
    y_s       = swap_s ? a : b;
    eff_sub_s = x_s[15] ^ y_s[15];
    x_exp_s   = (x_s[14:10] == 5'd0) ? 6'd1 : {1'b0, x_s[14:10]};
    y_exp_s   = (y_s[14:10] == 5'd0) ? 6'd1 : {1'b0, y_s[14:10]};
    x_man_s   = {x_s[14:10] != 5'd0, x_s[9:0], 3'b000};
    y_man_s   = {y_s[14:10] != 5'd0, y_s[9:0], 3'b000};
    diff_s    = x_exp_s - y_exp_s;
    shamt_s   = (diff_s > 6'd14) ? 6'd14 : diff_s;
    y_shift_s = {y_man_s, 14'd0} >> shamt_s;
    y_al_s    = y_shift_s[27:14] | {13'd0, |y_shift_s[13:0]};
    if (eff_sub_s) begin
      raw_s = {1'b0, x_man_s} - {1'b0, y_al_s};
    end else begin
      raw_s = {1'b0, x_man_s} + {1'b0, y_al_s};
    end
    if (raw_s[14]) begin
      norm_s = raw_s[14:1] | {13'd0, raw_s[0]};
      exp_s  = x_exp_s + 6'd1;
    end else begin
      norm_s = raw_s[13:0];
      exp_s  = x_exp_s;
    end
    for (int i = 0; i < 14; i++) begin
      if (!norm_s[13] && (exp_s > 6'd1)) begin
        norm_s = norm_s << 1;
        exp_s  = exp_s - 6'd1;
      end else begin
        norm_s = norm_s;
      end
    end
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s      = {1'b0, norm_s[13:3]} + {11'd0, round_up_s};
    man_s      = rnd_s[11] ? rnd_s[11:1] : rnd_s[10:0];
    exp_f_s    = exp_s + {5'd0, rnd_s[11]};

    if (fp16_is_nan(a) || fp16_is_nan(b)) begin
      sum = FP16_QNAN;
    end else if (fp16_is_inf(a) && fp16_is_inf(b)) begin
      sum = (a[15] != b[15]) ? FP16_QNAN : a;
    end else if (fp16_is_inf(a)) begin
      sum = a;
    end else if (fp16_is_inf(b)) begin
      sum = b;
    end else if (raw_s == 15'd0) begin
      sum = {x_s[15] & y_s[15], 15'd0};
    end else if (exp_f_s >= 6'd31) begin
      sum = {x_s[15], FP16_POS_INF[14:0]};
    end else begin
      sum = {x_s[15], man_s[10] ? exp_f_s[4:0] : 5'd0, man_s[9:0]};
    end
  end

endmodule

// File: rtl/fp16_stream_accumulator.sv
// Valid/ready fp16 burst reducer: keeps a running sum through fp16_adder and emits total, count and flags.
module fp16_stream_accumulator
  import fp16_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_inf,
  output logic             out_trunc
);

  acc_state_e       state_r;
  logic [15:0]      acc_r, sum_next_s, new_acc_s, out_sum_r;
  logic [CNT_W-1:0] cnt_r, new_cnt_s, out_count_r;
  logic             nan_sticky_r, in_ready_r, out_valid_r;
  logic             out_nan_r, out_inf_r, out_trunc_r;
  logic             accept_s, end_s;

  fp16_adder u_adder (
    .a   (acc_r),
    .b   (in_data),
    .sum (sum_next_s)
  );

  // The first term of a burst bypasses the adder so -0.0 and denormals are kept bit-exact.
  always_comb begin
    accept_s = in_valid && in_ready_r && !flush;
    if (state_r == ACC_IDLE) begin
      new_acc_s = in_data;
      new_cnt_s = CNT_W'(1);
    end else begin
      new_acc_s = sum_next_s;
      new_cnt_s = cnt_r + CNT_W'(1);
    end
    end_s = in_last || (new_cnt_s == CNT_W'(MAX_LEN));
  end

  // Burst FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACC_IDLE;
      acc_r        <= FP16_POS_ZERO;
      cnt_r        <= '0;
      nan_sticky_r <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_sum_r    <= FP16_POS_ZERO;
      out_count_r  <= '0;
      out_nan_r    <= 1'b0;
      out_inf_r    <= 1'b0;
      out_trunc_r  <= 1'b0;
    end else begin
      case (state_r)
        ACC_IDLE, ACC_ACCUM: begin
          if (flush) begin
            state_r      <= ACC_IDLE;
            acc_r        <= FP16_POS_ZERO;
            cnt_r        <= '0;
            nan_sticky_r <= 1'b0;
            in_ready_r   <= 1'b1;
          end else if (accept_s) begin
            acc_r        <= new_acc_s;
            cnt_r        <= new_cnt_s;
            nan_sticky_r <= nan_sticky_r | fp16_is_nan(new_acc_s);
            if (end_s) begin
              state_r     <= ACC_DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_sum_r   <= new_acc_s;
              out_count_r <= new_cnt_s;
              out_nan_r   <= nan_sticky_r | fp16_is_nan(new_acc_s);
              out_inf_r   <= fp16_is_inf(new_acc_s);
              out_trunc_r <= !in_last;
            end else begin
              state_r    <= ACC_ACCUM;
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ACC_DONE: begin
          if (out_ready) begin
            state_r      <= ACC_IDLE;
            acc_r        <= FP16_POS_ZERO;
            cnt_r        <= '0;
            nan_sticky_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
          end else begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ACC_IDLE;
          acc_r        <= FP16_POS_ZERO;
          cnt_r        <= '0;
          nan_sticky_r <= 1'b0;
          in_ready_r   <= 1'b0;
          out_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_count = out_count_r;
  assign out_nan   = out_nan_r;
  assign out_inf   = out_inf_r;
  assign out_trunc = out_trunc_r;

endmodule

// File: tb/tb_fp16_stream_accumulator.sv
// Directed self-checking bench for fp16_stream_accumulator with hand-computed fp16 totals.
module tb_fp16_stream_accumulator;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, in_last;
  logic             out_valid, out_ready, out_nan, out_inf, out_trunc;
  logic [15:0]      in_data, out_sum;
  logic [CNT_W-1:0] out_count;
  int               n_tests = 0;
  int               n_fail  = 0;

  always #5 clk = ~clk;

  fp16_stream_accumulator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_nan   (out_nan),
    .out_inf   (out_inf),
    .out_trunc (out_trunc)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one beat from a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [15:0] data, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [15:0] sum, input logic [15:0] mask,
                         input int cnt, input logic nan, input logic inf, input logic trunc);
    int waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_sum"}, out_sum & mask, sum & mask);
    check({tag, "_count"}, 16'(out_count), 16'(cnt));
    check({tag, "_nan"}, 16'(out_nan), 16'(nan));
    check({tag, "_inf"}, 16'(out_inf), 16'(inf));
    check({tag, "_trunc"}, 16'(out_trunc), 16'(trunc));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, 16'(out_valid), 16'd0);
    check({tag, "_rdy"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_sum", out_sum, 16'h0000);
    check("rst_out_count", 16'(out_count), 16'd0);
    check("rst_flags", {13'd0, out_nan, out_inf, out_trunc}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_in_ready0", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("rel_in_ready1", 16'(in_ready), 16'd1);

    // 1 + 1 + 2 = 4, result visible one cycle after the last accept
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    check("b2b_pre_valid", 16'(out_valid), 16'd0);
    send(16'h4000, 1'b1);
    check("b2b_latency", 16'(out_valid), 16'd1);
    collect("b2b", 16'h4400, 16'hFFFF, 3, 1'b0, 1'b0, 1'b0);

    send(16'h8000, 1'b1);
    collect("negzero", 16'h8000, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0);
    send(16'h0001, 1'b1);
    collect("denorm", 16'h0001, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0);

    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    collect("ovf", 16'h7C00, 16'hFFFF, 2, 1'b0, 1'b1, 1'b0);

    send(16'h7C00, 1'b0);
    send(16'hFC00, 1'b0);
    send(16'h3C00, 1'b1);
    check("nan_mant", 16'(out_sum[9:0] != 10'd0), 16'd1);
    collect("nan", 16'h7C00, 16'h7C00, 3, 1'b1, 1'b0, 1'b0);

    // Held result with a competing beat offered that must not be taken
    send(16'h3C00, 1'b1);
    in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 16'(out_valid), 16'd1);
      check("bp_sum", out_sum, 16'h3C00);
      check("bp_in_ready", 16'(in_ready), 16'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    collect("bp", 16'h3C00, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0);

    send(16'h4200, 1'b0);
    send(16'hC200, 1'b1);
    collect("cancel", 16'h0000, 16'hFFFF, 2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
    collect("maxlen", 16'h4400, 16'hFFFF, 4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(16'h3C00, i == 3);
    collect("maxlast", 16'h4400, 16'hFFFF, 4, 1'b0, 1'b0, 1'b0);

    send(16'h3C00, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    send(16'h3800, 1'b0);
    send(16'h3800, 1'b1);
    collect("flush", 16'h3C00, 16'hFFFF, 2, 1'b0, 1'b0, 1'b0);

    send(16'h3C00, 1'b1);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    check("done_flush_valid", 16'(out_valid), 16'd1);
    collect("done_flush", 16'h3C00, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0);

    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 16'(in_ready), 16'd0);
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_sum", out_sum, 16'h0000);
    check("mid_rst_count", 16'(out_count), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h4000, 1'b1);
    collect("post_rst", 16'h4000, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
